// File: rtl/leaf_credit_tx.sv
// Credit-based BFT transmit port: words from the kernel are queued and sent as data packets to one leaf/port.
// Latency: a word acked at t is on dout at t+2. Backpressure: ack drops while the queue is full; sends stall at zero credit.

module leaf_credit_fifo #(
    parameter int W          = 32,
    parameter int DEPTH_BITS = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_push,
    input  logic [W-1:0] i_dat,
    input  logic         i_pop,
    output logic [W-1:0] o_dat,
    output logic         o_empty,
    output logic         o_full
);
    localparam int DEPTH = 2 ** DEPTH_BITS;

    logic [W-1:0]          r_mem [DEPTH];
    logic [DEPTH_BITS-1:0] r_wr_ptr;
    logic [DEPTH_BITS-1:0] r_rd_ptr;
    logic [DEPTH_BITS:0]   r_count;

    always_ff @(posedge clk) begin
        if (i_push) r_mem[r_wr_ptr] <= i_dat;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (i_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_dat   = r_mem[r_rd_ptr];
    assign o_empty = (r_count == '0);
    assign o_full  = (r_count == (DEPTH_BITS + 1)'(DEPTH));
endmodule

module leaf_credit_tx #(
    parameter int PACKET_BITS     = 49,
    parameter int PAYLOAD_BITS    = 32,
    parameter int NUM_ADDR_BITS   = 7,
    parameter int FIFO_DEPTH_BITS = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    ap_start,
    input  logic [2:0]              dest_leaf,
    input  logic [3:0]              dest_port,
    input  logic [PAYLOAD_BITS-1:0] din_leaf_user2interface,
    input  logic                    vld_user2interface,
    output logic                    ack_interface2user,
    input  logic [PACKET_BITS-1:0]  din_leaf_bft2interface,
    output logic [PACKET_BITS-1:0]  dout_leaf_interface2bft,
    output logic [NUM_ADDR_BITS:0]  credit_count
);
    localparam int CW       = NUM_ADDR_BITS + 1;
    localparam int ADDR_LSB = PAYLOAD_BITS;
    localparam int TYPE_LSB = ADDR_LSB + NUM_ADDR_BITS;
    localparam int PORT_LSB = TYPE_LSB + 2;
    localparam int LEAF_LSB = PORT_LSB + 4;
    localparam int VLD_BIT  = LEAF_LSB + 3;

    localparam logic [CW:0] CREDIT_MAX = (CW + 1)'(2 ** NUM_ADDR_BITS);
    localparam logic [1:0]  TYPE_DATA  = 2'b00;
    localparam logic [1:0]  TYPE_FREE  = 2'b01;

    typedef enum logic {S_IDLE, S_RUN} state_t;

    state_t                   r_state;
    state_t                   w_state_nxt;
    logic [CW-1:0]            r_credit;
    logic [NUM_ADDR_BITS-1:0] r_wr_addr;
    logic [PACKET_BITS-1:0]   r_dout;

    logic                     w_fifo_empty;
    logic                     w_fifo_full;
    logic [PAYLOAD_BITS-1:0]  w_fifo_dat;
    logic                     w_send;
    logic                     w_push;
    logic                     w_upd;
    logic [7:0]               w_inc;
    logic [CW:0]              w_credit_sum;
    logic                     w_unused_din;

    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        if (r_state == S_IDLE && ap_start) w_state_nxt = S_RUN;
    end

    assign w_send = (r_state == S_RUN) && !w_fifo_empty && (r_credit != '0);
    // A pop in the same cycle frees the slot the incoming word lands in.
    assign w_push = vld_user2interface && (!w_fifo_full || w_send);
    assign ack_interface2user = w_push;

    leaf_credit_fifo #(
        .W          (PAYLOAD_BITS),
        .DEPTH_BITS (FIFO_DEPTH_BITS)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_push),
        .i_dat   (din_leaf_user2interface),
        .i_pop   (w_send),
        .o_dat   (w_fifo_dat),
        .o_empty (w_fifo_empty),
        .o_full  (w_fifo_full)
    );

    assign w_upd = din_leaf_bft2interface[VLD_BIT]
                && (din_leaf_bft2interface[TYPE_LSB +: 2] == TYPE_FREE)
                && (din_leaf_bft2interface[LEAF_LSB +: 3] == dest_leaf)
                && (din_leaf_bft2interface[PORT_LSB +: 4] == dest_port);
    assign w_inc = w_upd ? din_leaf_bft2interface[7:0] : 8'd0;
    assign w_unused_din = ^din_leaf_bft2interface[TYPE_LSB-1:8];

    // One bit of headroom so an oversized increment is clipped rather than wrapped.
    assign w_credit_sum = {1'b0, r_credit} - {{CW{1'b0}}, w_send} + {{(CW + 1 - 8){1'b0}}, w_inc};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_credit  <= CREDIT_MAX[CW-1:0];
            r_wr_addr <= '0;
            r_dout    <= '0;
        end else begin
            r_credit <= (w_credit_sum > CREDIT_MAX) ? CREDIT_MAX[CW-1:0] : w_credit_sum[CW-1:0];
            if (w_send) begin
                r_wr_addr <= r_wr_addr + 1'b1;
                r_dout    <= {1'b1, dest_leaf, dest_port, TYPE_DATA, r_wr_addr, w_fifo_dat};
            end else begin
                r_dout    <= '0;
            end
        end
    end

    assign dout_leaf_interface2bft = r_dout;
    assign credit_count            = r_credit;
endmodule

// File: tb/tb_leaf_credit_tx.sv
// Bench for leaf_credit_tx: queue-based reference of the credit protocol checked every cycle, plus directed literal checks.
module tb_leaf_credit_tx;
    logic        clk = 1'b0;
    logic        reset;
    logic        ap_start;
    logic [2:0]  dest_leaf;
    logic [3:0]  dest_port;
    logic [31:0] u_dat;
    logic        u_vld;
    logic        ack;
    logic [48:0] bft_din;
    logic [48:0] dout;
    logic [7:0]  credit;

    int n_checks = 0;
    int n_pass   = 0;
    bit model_on = 1'b0;

    logic [31:0] m_q[$];
    int          m_credit;
    int          m_addr;
    bit          m_run;
    logic [48:0] m_dout;

    always #5 clk = ~clk;

    leaf_credit_tx dut (
        .clk                     (clk),
        .reset                   (reset),
        .ap_start                (ap_start),
        .dest_leaf               (dest_leaf),
        .dest_port               (dest_port),
        .din_leaf_user2interface (u_dat),
        .vld_user2interface      (u_vld),
        .ack_interface2user      (ack),
        .din_leaf_bft2interface  (bft_din),
        .dout_leaf_interface2bft (dout),
        .credit_count            (credit)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    function automatic logic [48:0] mk(input logic v, input logic [2:0] l, input logic [3:0] p,
                                       input logic [1:0] t, input logic [6:0] a, input logic [31:0] pl);
        return {v, l, p, t, a, pl};
    endfunction

    // Reference: the local buffer is a queue, credits an integer, the address a counter mod 128.
    always @(negedge clk) begin
        if (model_on) begin : cmp
            bit send;
            bit exp_ack;
            bit upd;
            int inc;
            send    = m_run && (m_q.size() > 0) && (m_credit > 0);
            exp_ack = u_vld && ((m_q.size() < 4) || send);
            chk("ack", ack, exp_ack);
            if (!reset) begin
                chk("dout", dout, m_dout);
                chk("credit", credit, m_credit);
            end
            upd = bft_din[48] && (bft_din[40:39] == 2'b01) && (bft_din[47:45] == dest_leaf)
                  && (bft_din[44:41] == dest_port);
            inc = upd ? int'(bft_din[7:0]) : 0;
            if (reset) begin
                m_q.delete();
                m_credit = 128;
                m_addr   = 0;
                m_run    = 1'b0;
                m_dout   = '0;
            end else begin
                m_dout = '0;
                if (send) begin
                    m_dout = mk(1'b1, dest_leaf, dest_port, 2'b00, 7'(m_addr), m_q[0]);
                    void'(m_q.pop_front());
                    m_addr = (m_addr + 1) % 128;
                end
                if (exp_ack) m_q.push_back(u_dat);
                m_credit = m_credit - int'(send) + inc;
                if (m_credit > 128) m_credit = 128;
                if (ap_start) m_run = 1'b1;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic push_one(input logic [31:0] d, input int budget, output int cyc);
        cyc   = 0;
        u_vld = 1'b1;
        u_dat = d;
        for (int i = 1; i <= budget; i++) begin
            @(negedge clk);
            if (ack) cyc = i;
            tick();
            if (cyc != 0) break;
        end
        u_vld = 1'b0;
    endtask

    task automatic stream(input int n, input int budget);
        int got;
        int cyc;
        bit hit;
        got   = 0;
        cyc   = 0;
        u_vld = 1'b1;
        u_dat = $urandom;
        while (got < n && cyc < budget) begin
            @(negedge clk);
            hit = ack;
            tick();
            cyc++;
            if (hit) begin
                got++;
                u_dat = $urandom;
            end
            if (got == n) u_vld = 1'b0;
        end
        u_vld = 1'b0;
        chk("stream_count", got, n);
    endtask

    initial begin
        int          c;
        int          k;
        int          r;
        bit          found;
        bit          last_ack;
        logic [6:0]  a_seen;
        logic [48:0] bad [4];
        logic [63:0] rnd64;

        reset = 1'b1; ap_start = 1'b0; dest_leaf = 3'd2; dest_port = 4'd1;
        u_dat = '0; u_vld = 1'b0; bft_din = '0;
        model_on = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        chk("rst_dout", dout, 0);
        chk("rst_credit", credit, 128);

        // First word: acked at once, on dout two cycles after the ack.
        ap_start = 1'b1;
        push_one(32'hDEADBEEF, 5, c);
        chk("first_ack_cycle", c, 1);
        tick();
        chk("first_pkt", dout, 49'h1_4200_DEADBEEF);
        chk("first_credit", credit, 127);

        // Exhaust all 128 credits, fill the buffer, then release four with a +5 update.
        do_reset();
        stream(132, 400);
        repeat (3) tick();
        chk("credit_zero", credit, 0);
        push_one($urandom, 5, c);
        chk("full_noack", c, 0);
        bft_din = mk(1'b1, 3'd2, 4'd1, 2'b01, 7'd0, 32'd5);
        tick();
        bft_din = '0;
        k = 0;
        repeat (8) begin
            tick();
            if (dout[48]) begin
                chk("wrap_addr", dout[38:32], k);
                k++;
            end
        end
        chk("wrap_count", k, 4);
        chk("credit_after_upd5", credit, 1);

        // Zero credits, pending word, ignored and then valid updates.
        push_one($urandom, 5, c);
        repeat (3) tick();
        chk("credit_drained", credit, 0);
        push_one($urandom, 5, c);
        chk("pending_ack", c, 1);
        tick();
        bad[0] = mk(1'b1, 3'd3, 4'd1, 2'b01, 7'd0, 32'd1);
        bad[1] = mk(1'b1, 3'd2, 4'd2, 2'b01, 7'd0, 32'd1);
        bad[2] = mk(1'b1, 3'd2, 4'd1, 2'b00, 7'd0, 32'd1);
        bad[3] = mk(1'b0, 3'd2, 4'd1, 2'b01, 7'd0, 32'd1);
        for (int i = 0; i < 4; i++) begin
            bft_din = bad[i];
            tick();
            bft_din = '0;
            tick();
            chk("ignored_upd_credit", credit, 0);
            chk("ignored_upd_dout", dout[48], 0);
        end
        bft_din = mk(1'b1, 3'd2, 4'd1, 2'b01, 7'd0, 32'd1);
        tick();
        bft_din = '0;
        chk("upd_t1_credit", credit, 1);
        chk("upd_t1_dout", dout[48], 0);
        tick();
        chk("upd_t2_dout", dout[48], 1);
        chk("upd_t2_credit", credit, 0);

        // Saturation: credit 100, send and +64 in the same cycle.
        bft_din = mk(1'b1, 3'd2, 4'd1, 2'b01, 7'd0, 32'd100);
        tick();
        bft_din = '0;
        tick();
        chk("credit_100", credit, 100);
        push_one($urandom, 5, c);
        bft_din = mk(1'b1, 3'd2, 4'd1, 2'b01, 7'd0, 32'd64);
        tick();
        bft_din = '0;
        chk("sat_credit", credit, 128);
        chk("sat_dout", dout[48], 1);

        // Buffering while idle, then a back-to-back burst once started.
        ap_start = 1'b0;
        do_reset();
        stream(4, 10);
        push_one($urandom, 5, c);
        chk("idle_full_noack", c, 0);
        chk("idle_dout", dout, 0);
        ap_start = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("burst_vld", dout[48], 1);
            chk("burst_addr", dout[38:32], i);
        end
        tick();
        chk("burst_end", dout[48], 0);

        // Reset in the middle of a burst.
        ap_start = 1'b0;
        do_reset();
        stream(4, 10);
        ap_start = 1'b1;
        repeat (3) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("midrst_dout", dout, 0);
        chk("midrst_credit", credit, 128);
        repeat (4) begin
            tick();
            chk("midrst_empty", dout[48], 0);
        end
        push_one($urandom, 5, c);
        found  = 1'b0;
        a_seen = 7'h7f;
        for (int i = 0; i < 4 && !found; i++) begin
            tick();
            if (dout[48]) begin
                found  = 1'b1;
                a_seen = dout[38:32];
            end
        end
        chk("restart_seen", found, 1);
        chk("restart_addr", a_seen, 0);

        // Randomized traffic with a different destination.
        dest_leaf = 3'd5;
        dest_port = 4'd9;
        ap_start  = 1'b0;
        do_reset();
        last_ack = 1'b0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            reset = ($urandom_range(0, 299) == 0);
            if (reset) begin
                u_vld    = 1'b0;
                ap_start = 1'($urandom_range(0, 1));
            end else begin
                if ($urandom_range(0, 15) == 0) ap_start = 1'b1;
                if (!(u_vld && !last_ack)) begin
                    u_vld = ($urandom_range(0, 9) < 7);
                    u_dat = $urandom;
                end
            end
            r = $urandom_range(0, 19);
            if (r < 10) begin
                bft_din = '0;
            end else if (r < 15) begin
                bft_din = mk(1'b1, dest_leaf, dest_port, 2'b01, 7'($urandom),
                             {24'($urandom), 8'($urandom_range(0, 3))});
            end else if (r < 16) begin
                bft_din = mk(1'b1, dest_leaf, dest_port, 2'b01, 7'd0, 32'($urandom_range(0, 255)));
            end else begin
                rnd64   = {$urandom, $urandom};
                bft_din = rnd64[48:0];
            end
            @(negedge clk);
            last_ack = ack;
            tick();
        end
        reset   = 1'b0;
        u_vld   = 1'b0;
        bft_din = '0;
        repeat (10) tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
